// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: stage-5 write-back has fixed priority over the
// long-latency unit, with a pending-destination scoreboard and starvation bubble request.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wrreg,
    input  logic [31:0] wb_wrdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wrreg,
    input  logic [31:0] lu_wrdata,
    output logic        lu_ready,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_reg,
    input  logic [4:0]  chk_rs,
    input  logic [4:0]  chk_rt,
    output logic        hazard_stall,
    output logic        bubble_req,
    output logic        rf_we,
    output logic [4:0]  rf_wrreg,
    output logic [31:0] rf_wrdata,
    output logic        sb_err
);

    typedef enum logic [1:0] {IDLE, WAIT, BUBBLE} state_e;

    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             bubble_q;
    logic [31:0]      pending_q, pending_d, set_vec, clr_vec, live_vec;
    logic             sb_err_q, sb_err_d;
    logic             wb_win, lu_ok;

    // Gating with rst_n keeps the write port and handshake quiet while reset is held.
    assign wb_win = rst_n && wb_regwrite && (wb_wrreg != 5'd0);
    assign lu_ok  = rst_n && lu_valid && !wb_win;

    always_comb begin
        rf_we     = 1'b0;
        rf_wrreg  = 5'd0;
        rf_wrdata = 32'd0;
        lu_ready  = 1'b0;
        if (wb_win) begin
            rf_we     = 1'b1;
            rf_wrreg  = wb_wrreg;
            rf_wrdata = wb_wrdata;
        end else if (lu_ok) begin
            rf_we     = (lu_wrreg != 5'd0);
            rf_wrreg  = lu_wrreg;
            rf_wrdata = lu_wrdata;
            lu_ready  = 1'b1;
        end
    end

    // A retire and re-issue of the same register in one cycle is legal, so the
    // double-issue check looks at pending bits after this cycle's clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lu_issue) set_vec[lu_issue_reg] = 1'b1;
        if (lu_ready) clr_vec[lu_wrreg] = 1'b1;
        live_vec  = pending_q & ~clr_vec;
        pending_d = (live_vec | set_vec) & ~32'd1;
        sb_err_d  = sb_err_q | (lu_issue && (lu_issue_reg != 5'd0) && live_vec[lu_issue_reg]);
    end

    assign hazard_stall = pending_q[chk_rs] | pending_q[chk_rt];

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lu_valid && !lu_ok) begin
                    cnt_d   = CNT_ONE;
                    state_d = (SMAX <= CNT_ONE) ? BUBBLE : WAIT;
                end
            end
            WAIT: begin
                if (lu_ok || !lu_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= SMAX) state_d = BUBBLE;
                end
            end
            BUBBLE: begin
                if (lu_ok || !lu_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bubble_q  <= 1'b0;
            pending_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bubble_q  <= (state_d == BUBBLE);
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign bubble_req = bubble_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares the full output tuple each cycle.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_regwrite, lu_valid, lu_issue;
    logic [4:0]  wb_wrreg, lu_wrreg, lu_issue_reg, chk_rs, chk_rt;
    logic [31:0] wb_wrdata, lu_wrdata;
    logic        lu_ready, hazard_stall, bubble_req, rf_we, sb_err;
    logic [4:0]  rf_wrreg;
    logic [31:0] rf_wrdata;

    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        rdy;
        logic        haz;
        logic        bub;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t e_m, a_m;
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_regwrite(wb_regwrite), .wb_wrreg(wb_wrreg), .wb_wrdata(wb_wrdata),
        .lu_valid(lu_valid), .lu_wrreg(lu_wrreg), .lu_wrdata(lu_wrdata), .lu_ready(lu_ready),
        .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .hazard_stall(hazard_stall),
        .bubble_req(bubble_req), .rf_we(rf_we), .rf_wrreg(rf_wrreg), .rf_wrdata(rf_wrdata),
        .sb_err(sb_err)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_m = q.pop_front();
            a_m = {rf_we, rf_wrreg, rf_wrdata, lu_ready, hazard_stall, bubble_req, sb_err};
            checks++;
            step_no++;
            if (a_m !== e_m) begin
                failures++;
                $display("FAIL step%0d: got we=%b reg=%0d data=%h rdy=%b haz=%b bub=%b err=%b, want we=%b reg=%0d data=%h rdy=%b haz=%b bub=%b err=%b",
                         step_no, a_m.we, a_m.wreg, a_m.wdata, a_m.rdy, a_m.haz, a_m.bub, a_m.err,
                         e_m.we, e_m.wreg, e_m.wdata, e_m.rdy, e_m.haz, e_m.bub, e_m.err);
            end
        end
    end

    function automatic void ex(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                               input logic rdy, input logic haz, input logic bub, input logic err);
        q.push_back({we, wreg, wdata, rdy, haz, bub, err});
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_regwrite = 1'b0; wb_wrreg = 5'd0; wb_wrdata = 32'd0;
        lu_valid = 1'b0; lu_wrreg = 5'd0; lu_wrdata = 32'd0;
        lu_issue = 1'b0; lu_issue_reg = 5'd0;
        chk_rs = 5'd0; chk_rt = 5'd0;
    endtask

    task automatic set_wb(input logic [4:0] r, input logic [31:0] d);
        wb_regwrite = 1'b1; wb_wrreg = r; wb_wrdata = d;
    endtask

    task automatic set_lu(input logic [4:0] r, input logic [31:0] d);
        lu_valid = 1'b1; lu_wrreg = r; lu_wrdata = d;
    endtask

    task automatic set_iss(input logic [4:0] r);
        lu_issue = 1'b1; lu_issue_reg = r;
    endtask

    initial begin
        idle();
        // Contending requests while reset is held must produce nothing.
        set_wb(5'd3, 32'h33); set_lu(5'd7, 32'h77);
        cyc(); ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); rst_n = 1'b1; idle(); ex(0, 0, 0, 0, 0, 0, 0);

        // Issue reg5, then retire it.
        cyc(); idle(); set_iss(5'd5); chk_rs = 5'd5; ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); idle(); chk_rs = 5'd5; set_lu(5'd5, 32'hDEADBEEF); ex(1, 5'd5, 32'hDEADBEEF, 1, 1, 0, 0);
        cyc(); idle(); chk_rt = 5'd5; ex(0, 0, 0, 0, 0, 0, 0);

        // Write-back wins, LU goes next cycle.
        cyc(); idle(); set_wb(5'd3, 32'h33); set_lu(5'd7, 32'h77); ex(1, 5'd3, 32'h33, 0, 0, 0, 0);
        cyc(); idle(); set_lu(5'd7, 32'h77); ex(1, 5'd7, 32'h77, 1, 0, 0, 0);
        cyc(); idle(); ex(0, 0, 0, 0, 0, 0, 0);

        // Starvation: bubble_req on the fifth blocked cycle.
        for (int i = 1; i <= 6; i++) begin
            cyc(); idle(); set_wb(5'd4, 32'h44); set_lu(5'd8, 32'h88);
            ex(1, 5'd4, 32'h44, 0, 0, (i >= 5), 0);
        end
        cyc(); idle(); set_lu(5'd8, 32'h88); ex(1, 5'd8, 32'h88, 1, 0, 1, 0);
        cyc(); idle(); ex(0, 0, 0, 0, 0, 0, 0);

        // $0 handling.
        cyc(); idle(); set_wb(5'd0, 32'h11); set_lu(5'd10, 32'hAA); ex(1, 5'd10, 32'hAA, 1, 0, 0, 0);
        cyc(); idle(); set_iss(5'd0); ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); idle(); set_iss(5'd0); ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); idle(); set_lu(5'd0, 32'h55); ex(0, 5'd0, 32'h55, 1, 0, 0, 0);

        // Same-cycle retire and re-issue, then a genuine double issue.
        cyc(); idle(); set_iss(5'd9); ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); idle(); set_lu(5'd9, 32'h99); set_iss(5'd9); chk_rs = 5'd9; ex(1, 5'd9, 32'h99, 1, 1, 0, 0);
        cyc(); idle(); chk_rs = 5'd9; ex(0, 0, 0, 0, 1, 0, 0);
        cyc(); idle(); set_iss(5'd9); chk_rt = 5'd9; ex(0, 0, 0, 0, 1, 0, 0);
        cyc(); idle(); chk_rs = 5'd9; ex(0, 0, 0, 0, 1, 0, 1);
        cyc(); idle(); set_iss(5'd8); ex(0, 0, 0, 0, 0, 0, 1);
        cyc(); idle(); set_iss(5'd10); ex(0, 0, 0, 0, 0, 0, 1);
        cyc(); idle(); set_iss(5'd11); ex(0, 0, 0, 0, 0, 0, 1);
        cyc(); idle(); chk_rs = 5'd8; chk_rt = 5'd11; ex(0, 0, 0, 0, 1, 0, 1);
        cyc(); idle(); chk_rs = 5'd12; chk_rt = 5'd7; ex(0, 0, 0, 0, 0, 0, 1);

        // Reach BUBBLE with pending=0x0F00, then async reset mid-cycle.
        for (int i = 1; i <= 5; i++) begin
            cyc(); idle(); set_wb(5'd1, 32'h1); set_lu(5'd12, 32'hC); chk_rs = 5'd10;
            ex(1, 5'd1, 32'h1, 0, 1, (i >= 5), 1);
        end
        cyc(); rst_n = 1'b0; ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); idle(); chk_rs = 5'd9; ex(0, 0, 0, 0, 0, 0, 0);
        cyc(); rst_n = 1'b1; chk_rs = 5'd9; chk_rt = 5'd11; ex(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never compared, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
